// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
//   Operand, control and HI/LO result bundle between the control path and
//   the iterative multiply/divide unit.
//   master: control path (drives start/op/operands/MTHI/MTLO writes)
//   slave : muldiv_unit (drives busy/done/hi/lo)
//   Signals: start, op[1:0], rs_data, rt_data, hi_we, lo_we, wdata,
//            busy, done, hi, lo
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO register pair.
//   One operation takes 34 cycles: 1 launch edge, 32 iteration edges, 1 fix edge.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - muldiv_unit_if.slave (start/op/operands/MTHI/MTLO in, busy/done/hi/lo out)
//   Build option:
//     MULDIV_SIGNED_EN - when defined, op[0]=0 selects signed MULT/DIV; when
//                        undefined all operations are unsigned and op[0] is ignored.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; MTHI/MTLO writes accepted here
//   RUN   | 32 shift-add / restoring-divide iterations, counter 0..31
//   FIX   | sign correction, HI/LO update, done pulse
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               div0_q, div0_d;
    // opnd: multiplicand (mul) or divisor (div) magnitude
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    // acc_hi: running product high half / 33-bit partial remainder
    // acc_lo: multiplier being shifted out / dividend shifting into quotient
    logic [WIDTH:0]     acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_trial;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
    logic signed_op, sign_a, sign_b;
    logic neg_q_q, neg_q_d;
    logic neg_r_q, neg_r_d;

    assign signed_op = ~bus.op[0];
    assign sign_a    = signed_op & bus.rs_data[WIDTH-1];
    assign sign_b    = signed_op & bus.rt_data[WIDTH-1];
    assign mag_a     = sign_a ? -bus.rs_data : bus.rs_data;
    assign mag_b     = sign_b ? -bus.rt_data : bus.rt_data;
`else
    assign mag_a     = bus.rs_data;
    assign mag_b     = bus.rt_data;
`endif

    // One iteration of each datapath; only the one matching is_div_q is used.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q[WIDTH-1:0]}
                  + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        // acc_hi_q[WIDTH] is always 0 here since the remainder stays below the divisor
        div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]} - {2'b00, opnd_q};
        div_ge    = ~div_trial[WIDTH+1];
    end

    // Final result with sign correction. Divide-by-zero still yields the
    // dividend as remainder (|A| re-signed by A's sign), so only LO needs forcing.
    always_comb begin
        prod = {acc_hi_q[WIDTH-1:0], acc_lo_q};
        quo  = acc_lo_q;
        rem  = acc_hi_q[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
        if (neg_q_q) begin
            prod = -prod;
            quo  = -quo;
        end
        if (neg_r_q) begin
            rem = -rem;
        end
`endif
        if (is_div_q) begin
            res_hi = rem;
            res_lo = div0_q ? '1 : quo;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
`ifdef MULDIV_SIGNED_EN
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    is_div_d = bus.op[1];
                    div0_d   = bus.op[1] & (bus.rt_data == '0);
                    opnd_d   = bus.op[1] ? mag_b : mag_a;
                    acc_lo_d = bus.op[1] ? mag_a : mag_b;
                    acc_hi_d = '0;
                    cnt_d    = 5'd0;
`ifdef MULDIV_SIGNED_EN
                    neg_q_d  = sign_a ^ sign_b;
                    neg_r_d  = sign_a;
`endif
                    state_d  = RUN;
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    acc_hi_d = div_ge ? div_trial[WIDTH:0]
                                      : {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_hi_d = {1'b0, mul_sum[WIDTH:1]};
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
`ifdef MULDIV_SIGNED_EN
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit holding the HI/LO register pair. It sits directly downstream of the general-purpose register file: its operands are the register file's two read-data outputs. It executes MULT, MULTU, DIV and DIVU over 33 cycles, raising `busy` so the control path can stall dependent MFHI/MFLO. It also services MTHI/MTLO writes and drives HI/LO to the writeback mux.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width; only 32 is supported.

Ports:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: launches an operation; sampled only in IDLE.
- `op` input 2: operation code; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data` input 32: operand A (multiplicand or dividend), from register file read port 1.
- `rt_data` input 32: operand B (multiplier or divisor), from register file read port 2.
- `hi_we` input 1: MTHI write enable.
- `lo_we` input 1: MTLO write enable.
- `wdata` input 32: MTHI/MTLO data (= `rs_data` path).
- `busy` output 1: operation in progress; the control path stalls MFHI/MFLO/new muldiv.
- `done` output 1: one-cycle pulse when HI/LO have just been updated.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
FSM states:
- **IDLE**
  - If `start`: latch `op`, the operand magnitudes (absolute value for signed ops), and result-sign flags (quotient/product sign = sign A xor sign B; remainder sign = sign A). Clear a 5-bit counter and go to RUN.
- **RUN**
  - One iteration per cycle for 32 cycles.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring divide, one quotient bit per cycle, 33-bit partial remainder.
  - When the counter wraps from 31 to 0, go to FIX.
- **FIX**
  - Apply sign correction (two's-complement negate) for signed ops.
  - Write HI/LO, pulse `done`, return to IDLE.

Results:
- Multiply: HI = product[63:32], LO = product[31:0].
- Divide: LO = quotient, HI = remainder; the remainder takes the dividend's sign.
- Divide by zero, either sign: LO = 0xFFFFFFFF, HI = `rs_data` as latched.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wraps, no trap).

MTHI/MTLO:
- In IDLE with `start` low, `hi_we`/`lo_we` write `wdata` on the edge.
- Both asserted together write both registers.
- Ignored while `busy`.
- `start` together with `hi_we`/`lo_we` in IDLE: the operation starts and the write is dropped.

Other rules:
- `start` while busy is ignored; the operation in flight is not disturbed.
- HI/LO hold their previous values throughout RUN; they change only at the FIX edge or on an MTHI/MTLO write.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0.
- Reset asserted mid-operation aborts immediately with the same values; no partial result is written.
- Let `start` be sampled at edge E0:
  - `busy` is high from after E0 through the cycle before E33.
  - Edges E1..E32 are the iterations; E33 is FIX.
  - After E33, `hi`/`lo` hold the new result, `done`=1 for exactly one cycle, and `busy`=0.
- A new `start` may be accepted at E34, i.e. in the cycle where `done` is high.
- Back-to-back throughput: one operation per 34 cycles.
- MTHI/MTLO latency: visible on `hi`/`lo` one edge after the write.
- `hi`/`lo` are registered outputs with no combinational path from inputs.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - MULT and DIV are signed as described.
  - The abs/negate logic and sign flags are compiled in.
- Not defined:
  - The sign logic is removed.
  - MULT behaves exactly as MULTU and DIV exactly as DIVU; `op[0]` is ignored.
  - Latency is unchanged (FIX still takes one cycle).

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 edges HI=0xFFFFFFFE, LO=0x00000001, `done` one cycle, `busy` low.
- MULT -3 × 7 (0xFFFFFFFD, 7) → HI=0xFFFFFFFF, LO=0xFFFFFFEB (with `MULDIV_SIGNED_EN`); without the macro → HI=0x00000006, LO=0xFFFFFFEB.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 0 → LO=0xFFFFFFFF, HI=100.
- MTHI 0x1234 in IDLE → `hi`=0x1234 next edge; `lo_we` pulsed during RUN of DIVU 9/4 → ignored, final LO=2, HI=1.
- Second `start` at cycle 10 of an operation → ignored, first result intact; a `start` issued in the `done` cycle is accepted.
- `rst_n` low at cycle 15 of MULT 5×5 → `busy`=0, HI=LO=0 immediately, no `done` pulse after release.
